weight_pingpong_buffer: RTL and testbench



---
 rtl/wbuf_pkg.sv | 22 ++
 rtl/weight_pingpong_buffer_if.sv | 37 +++
 rtl/wbuf_bank.sv | 35 +++
 rtl/weight_pingpong_buffer.sv | 139 +++++++++++++
 tb/tb_weight_pingpong_buffer.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/wbuf_pkg.sv
// Shared types and address helpers for the weight ping-pong buffer.
package wbuf_pkg;

  // Occupancy of one weight bank.
  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_e;

  // Low sub_bits of a write beat address: which sub-word of the read word.
  function automatic logic [31:0] sub_idx(input logic [31:0] addr, input int unsigned sub_bits);
    logic [31:0] mask_s;
    mask_s = (32'd1 << sub_bits) - 32'd1;
    return addr & mask_s;
  endfunction

  // Remaining high bits of a write beat address: the read-word index.
  function automatic logic [31:0] word_idx(input logic [31:0] addr, input int unsigned sub_bits);
    return addr >> sub_bits;
  endfunction

endpackage

// File: rtl/weight_pingpong_buffer_if.sv
// Write-stream and read-side signals of the weight ping-pong buffer.
// master: DMA loader plus PE-array consumer; slave: the buffer itself.
interface weight_pingpong_buffer_if #(
  parameter int WR_DATA_W = 64,
  parameter int RATIO     = 2,
  parameter int DEPTH     = 512
);
  localparam int RD_DATA_W = WR_DATA_W * RATIO;
  localparam int RD_ADDR_W = $clog2(DEPTH);
  localparam int WR_ADDR_W = $clog2(DEPTH * RATIO);

  logic                 wr_valid;
  logic                 wr_ready;
  logic [WR_DATA_W-1:0] wr_data;
  logic [WR_ADDR_W-1:0] wr_addr;
  logic                 wr_last;
  logic                 rd_en;
  logic [RD_ADDR_W-1:0] rd_addr;
  logic                 rd_release;
  logic                 rd_bank_ready;
  logic [RD_DATA_W-1:0] weight_vec;
  logic                 weight_valid;
  logic                 wr_bank;
  logic                 rd_bank;
  logic                 rd_err;

  modport master (
    output wr_valid, wr_data, wr_addr, wr_last, rd_en, rd_addr, rd_release,
    input  wr_ready, rd_bank_ready, weight_vec, weight_valid, wr_bank, rd_bank, rd_err
  );

  modport slave (
    input  wr_valid, wr_data, wr_addr, wr_last, rd_en, rd_addr, rd_release,
    output wr_ready, rd_bank_ready, weight_vec, weight_valid, wr_bank, rd_bank, rd_err
  );

endinterface

// File: rtl/wbuf_bank.sv
// One weight bank: DEPTH wide words, per-sub-word write enables,
// synchronous registered read. Contents and read register are never reset.
module wbuf_bank #(
  parameter int WR_DATA_W = 64,
  parameter int RATIO     = 2,
  parameter int DEPTH     = 512
) (
  input  logic                           clk,
  input  logic [RATIO-1:0]               we,
  input  logic [$clog2(DEPTH)-1:0]       waddr,
  input  logic [WR_DATA_W*RATIO-1:0]     wdata,
  input  logic                           re,
  input  logic [$clog2(DEPTH)-1:0]       raddr,
  output logic [WR_DATA_W*RATIO-1:0]     rdata
);

  (* ram_style = "block" *) logic [WR_DATA_W*RATIO-1:0] mem_r [DEPTH];

  // Byte-lane style write: only enabled sub-words of the addressed word change.
  always_ff @(posedge clk) begin
    for (int k = 0; k < RATIO; k++) begin
      if (we[k]) begin
        mem_r[waddr][k*WR_DATA_W +: WR_DATA_W] <= wdata[k*WR_DATA_W +: WR_DATA_W];
      end
    end
  end

  // Registered read port; holds its last word while re is low.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/weight_pingpong_buffer.sv
// Double-buffered weight store: the loader fills bank wb while the PE array
// reads bank rb. Narrow beats are packed RATIO-to-one into wide read words.
// A bank is writable only while EMPTY and readable only while FULL, so weights
// in use can never be overwritten.
module weight_pingpong_buffer
  import wbuf_pkg::*;
#(
  parameter int WR_DATA_W = 64,
  parameter int RATIO     = 2,
  parameter int DEPTH     = 512
) (
  input  logic                      clk,
  input  logic                      rst_n,
  weight_pingpong_buffer_if.slave   bus
);

  localparam int          RD_DATA_W = WR_DATA_W * RATIO;
  localparam int          RD_ADDR_W = $clog2(DEPTH);
  localparam int unsigned SUB_BITS  = $clog2(RATIO);

  bank_state_e          state_r [2];
  bank_state_e          state_n_s [2];
  logic                 wb_r, wb_n_s;
  logic                 rb_r, rb_n_s;
  logic                 rd_sel_r;
  logic                 weight_valid_r;
  logic                 rd_err_r;

  logic                 wr_ready_s;
  logic                 rd_ready_s;
  logic                 wr_fire_s;
  logic                 commit_s;
  logic                 rd_fire_s;
  logic                 release_s;
  logic                 err_s;

  logic [31:0]          wr_sub_s;
  logic [RD_ADDR_W-1:0] wr_word_s;
  logic [RATIO-1:0]     sub_oh_s;
  logic [RATIO-1:0]     bank_we_s [2];
  logic                 bank_re_s [2];
  logic [RD_DATA_W-1:0] bank_q_s  [2];

  // Handshake qualifiers; readiness depends on bank state only.
  assign wr_ready_s = (state_r[wb_r] == BANK_EMPTY);
  assign rd_ready_s = (state_r[rb_r] == BANK_FULL);
  assign wr_fire_s  = bus.wr_valid & wr_ready_s;
  assign commit_s   = wr_fire_s & bus.wr_last;
  assign rd_fire_s  = bus.rd_en & rd_ready_s;
  assign release_s  = bus.rd_release & rd_ready_s;
  assign err_s      = (bus.rd_en | bus.rd_release) & ~rd_ready_s;

  assign wr_sub_s  = sub_idx(32'(bus.wr_addr), SUB_BITS);
  assign wr_word_s = RD_ADDR_W'(word_idx(32'(bus.wr_addr), SUB_BITS));

  // Route an accepted beat to one sub-word lane of the current fill bank.
  always_comb begin
    bank_we_s[0] = {RATIO{1'b0}};
    bank_we_s[1] = {RATIO{1'b0}};
    for (int k = 0; k < RATIO; k++) begin
      sub_oh_s[k] = (wr_sub_s == 32'(k));
    end
    if (wr_fire_s) begin
      bank_we_s[wb_r] = sub_oh_s;
    end else begin
      bank_we_s[wb_r] = {RATIO{1'b0}};
    end
  end

  assign bank_re_s[0] = rd_fire_s & ~rb_r;
  assign bank_re_s[1] = rd_fire_s &  rb_r;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    wbuf_bank #(
      .WR_DATA_W (WR_DATA_W),
      .RATIO     (RATIO),
      .DEPTH     (DEPTH)
    ) u_bank (
      .clk   (clk),
      .we    (bank_we_s[b]),
      .waddr (wr_word_s),
      .wdata ({RATIO{bus.wr_data}}),
      .re    (bank_re_s[b]),
      .raddr (bus.rd_addr),
      .rdata (bank_q_s[b])
    );
  end

  // Next bank states and pointers; commit and release never hit the same bank.
  always_comb begin
    state_n_s[0] = state_r[0];
    state_n_s[1] = state_r[1];
    wb_n_s       = wb_r;
    rb_n_s       = rb_r;
    if (commit_s) begin
      state_n_s[wb_r] = BANK_FULL;
      wb_n_s          = ~wb_r;
    end else begin
      wb_n_s          = wb_r;
    end
    if (release_s) begin
      state_n_s[rb_r] = BANK_EMPTY;
      rb_n_s          = ~rb_r;
    end else begin
      rb_n_s          = rb_r;
    end
  end

  // Bank state, pointers, read-valid pipeline and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r[0]     <= BANK_EMPTY;
      state_r[1]     <= BANK_EMPTY;
      wb_r           <= 1'b0;
      rb_r           <= 1'b0;
      rd_sel_r       <= 1'b0;
      weight_valid_r <= 1'b0;
      rd_err_r       <= 1'b0;
    end else begin
      state_r[0]     <= state_n_s[0];
      state_r[1]     <= state_n_s[1];
      wb_r           <= wb_n_s;
      rb_r           <= rb_n_s;
      rd_sel_r       <= rd_fire_s ? rb_r : rd_sel_r;
      weight_valid_r <= rd_fire_s;
      rd_err_r       <= rd_err_r | err_s;
    end
  end

  // The output mux select only moves on an accepted read, so weight_vec holds otherwise.
  assign bus.weight_vec    = bank_q_s[rd_sel_r];
  assign bus.weight_valid  = weight_valid_r;
  assign bus.wr_ready      = wr_ready_s;
  assign bus.rd_bank_ready = rd_ready_s;
  assign bus.wr_bank       = wb_r;
  assign bus.rd_bank       = rb_r;
  assign bus.rd_err        = rd_err_r;

endmodule

// File: tb/tb_weight_pingpong_buffer.sv
// Self-checking bench for weight_pingpong_buffer (WR_DATA_W=64, RATIO=2, DEPTH=4).
// A reference model of bank states, pointers and memory predicts every output;
// read results are queued on issue and compared when weight_valid appears.
module tb_weight_pingpong_buffer;

  logic clk;
  logic rst_n;

  weight_pingpong_buffer_if #(.WR_DATA_W(64), .RATIO(2), .DEPTH(4)) bus ();

  weight_pingpong_buffer #(.WR_DATA_W(64), .RATIO(2), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model
  logic [127:0] mem_m [2][4];
  bit           full_m [2];
  bit           wb_m, rb_m, err_m;
  logic [127:0] sb_q [$];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every weight_valid must match the oldest predicted read.
  always @(negedge clk) begin
    if (rst_n && bus.weight_valid) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_unexp_valid", 128'(bus.weight_valid), 128'd0);
      end else begin
        check_eq("weight_vec", bus.weight_vec, sb_q.pop_front());
      end
    end
  end

  task automatic idle_inputs();
    bus.wr_valid   = 1'b0;
    bus.wr_data    = 64'd0;
    bus.wr_addr    = 3'd0;
    bus.wr_last    = 1'b0;
    bus.rd_en      = 1'b0;
    bus.rd_addr    = 2'd0;
    bus.rd_release = 1'b0;
  endtask

  // One clock cycle of stimulus, model update and output checks.
  task automatic step(input bit wv, input logic [2:0] wa, input logic [63:0] wd, input bit wl,
                      input bit re, input logic [1:0] ra, input bit rr);
    bit w_ok, r_ok, exp_v;
    bus.wr_valid   = wv;
    bus.wr_addr    = wa;
    bus.wr_data    = wd;
    bus.wr_last    = wl;
    bus.rd_en      = re;
    bus.rd_addr    = ra;
    bus.rd_release = rr;
    w_ok = !full_m[wb_m];
    r_ok = full_m[rb_m];
    check_eq("wr_ready", 128'(bus.wr_ready), 128'(w_ok));
    check_eq("rd_bank_ready", 128'(bus.rd_bank_ready), 128'(r_ok));
    exp_v = re && r_ok;
    if (exp_v) sb_q.push_back(mem_m[rb_m][ra]);
    if ((re || rr) && !r_ok) err_m = 1'b1;
    if (wv && w_ok) begin
      if (wa[0]) mem_m[wb_m][wa[2:1]][127:64] = wd;
      else       mem_m[wb_m][wa[2:1]][63:0]   = wd;
      if (wl) begin
        full_m[wb_m] = 1'b1;
        wb_m = ~wb_m;
      end
    end
    if (rr && r_ok) begin
      full_m[rb_m] = 1'b0;
      rb_m = ~rb_m;
    end
    @(posedge clk);
    #1;
    check_eq("wr_bank", 128'(bus.wr_bank), 128'(wb_m));
    check_eq("rd_bank", 128'(bus.rd_bank), 128'(rb_m));
    check_eq("rd_err", 128'(bus.rd_err), 128'(err_m));
    check_eq("weight_valid", 128'(bus.weight_valid), 128'(exp_v));
    idle_inputs();
  endtask

  task automatic idle_step();
    step(1'b0, 3'd0, 64'd0, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic fill_bank(input logic [63:0] base);
    for (int a = 0; a < 8; a++) begin
      step(1'b1, 3'(a), base + 64'(a), (a == 7), 1'b0, 2'd0, 1'b0);
    end
  endtask

  // Assert reset between edges, check reset outputs, release on a falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    full_m[0] = 1'b0;
    full_m[1] = 1'b0;
    wb_m  = 1'b0;
    rb_m  = 1'b0;
    err_m = 1'b0;
    sb_q.delete();
    #2;
    check_eq("rst_wr_ready", 128'(bus.wr_ready), 128'd1);
    check_eq("rst_rd_bank_ready", 128'(bus.rd_bank_ready), 128'd0);
    check_eq("rst_weight_valid", 128'(bus.weight_valid), 128'd0);
    check_eq("rst_rd_err", 128'(bus.rd_err), 128'd0);
    check_eq("rst_wr_bank", 128'(bus.wr_bank), 128'd0);
    check_eq("rst_rd_bank", 128'(bus.rd_bank), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    for (int b = 0; b < 2; b++) for (int w = 0; w < 4; w++) mem_m[b][w] = 128'd0;
    @(posedge clk);
    #1;

    // 1: reset state
    do_reset();

    // 2: fill bank 0, read word 2, check one-cycle latency and hold
    fill_bank(64'h10);
    step(1'b0, 3'd0, 64'd0, 1'b0, 1'b1, 2'd2, 1'b0);
    check_eq("s2_valid", 128'(bus.weight_valid), 128'd1);
    check_eq("s2_vec", bus.weight_vec, {64'h15, 64'h14});
    idle_step();
    check_eq("s2_hold", bus.weight_vec, {64'h15, 64'h14});

    // 3: fill both banks, third beat stalls, release frees bank 0
    do_reset();
    fill_bank(64'hA0);
    fill_bank(64'hB0);
    check_eq("s3_stall", 128'(bus.wr_ready), 128'd0);
    step(1'b1, 3'd0, 64'hDEAD_BEEF, 1'b1, 1'b0, 2'd0, 1'b0);
    step(1'b0, 3'd0, 64'd0, 1'b0, 1'b0, 2'd0, 1'b1);
    check_eq("s3_wr_ready", 128'(bus.wr_ready), 128'd1);
    check_eq("s3_wr_bank", 128'(bus.wr_bank), 128'd0);
    for (int w = 0; w < 4; w++) step(1'b0, 3'd0, 64'd0, 1'b0, 1'b1, 2'(w), 1'b0);
    idle_step();

    // 4: ping-pong, read bank 0 while filling bank 1, commit+release together
    do_reset();
    fill_bank(64'hC0);
    for (int a = 0; a < 8; a++) begin
      step(1'b1, 3'(a), 64'hD0 + 64'(a), (a == 7), 1'b1, 2'(a % 4), (a == 7));
    end
    check_eq("s4_rd_bank", 128'(bus.rd_bank), 128'd1);
    check_eq("s4_wr_bank", 128'(bus.wr_bank), 128'd0);
    for (int w = 3; w >= 0; w--) step(1'b0, 3'd0, 64'd0, 1'b0, 1'b1, 2'(w), 1'b0);
    step(1'b0, 3'd0, 64'd0, 1'b0, 1'b0, 2'd0, 1'b1);
    check_eq("s4_empty", 128'(bus.rd_bank_ready), 128'd0);

    // 5: read with no FULL bank
    do_reset();
    step(1'b0, 3'd0, 64'd0, 1'b0, 1'b1, 2'd1, 1'b0);
    check_eq("s5_err", 128'(bus.rd_err), 128'd1);
    check_eq("s5_valid", 128'(bus.weight_valid), 128'd0);
    repeat (3) idle_step();
    check_eq("s5_err_held", 128'(bus.rd_err), 128'd1);

    // 6: reset mid-fill after three beats into bank 1
    do_reset();
    fill_bank(64'hE0);
    for (int a = 0; a < 3; a++) step(1'b1, 3'(a), 64'hF0 + 64'(a), 1'b0, 1'b0, 2'd0, 1'b0);
    do_reset();
    step(1'b0, 3'd0, 64'd0, 1'b0, 1'b0, 2'd0, 1'b1);
    check_eq("s6_rd_bank_ready", 128'(bus.rd_bank_ready), 128'd0);
    check_eq("s6_wr_ready", 128'(bus.wr_ready), 128'd1);
    check_eq("s6_wr_bank", 128'(bus.wr_bank), 128'd0);

    repeat (2) idle_step();
    check_eq("sb_drain", 128'(sb_q.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
